ysyx_22040383_mem_stage: RTL and testbench

- Memory-access stage of the five-stage pipeline; sits between EX and the writeback stage.
- Accepts one instruction from EX per handshake, performs load/store through a single-outstanding req/ack data-memory port, and formats load data.
- Drives the registered MEM/WB outputs: write-back data, rd address, write enable.
- Non-memory instructions pass through with 1-cycle latency; memory instructions stall EX until dmem_ack.

---
 rtl/ysyx_22040383_mem_stage_pkg.sv | 39 +++
 rtl/ysyx_22040383_lsu_align.sv | 58 +++++
 rtl/ysyx_22040383_mem_stage.sv | 146 ++++++++++++++
 tb/tb_ysyx_22040383_mem_stage.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040383_mem_stage_pkg.sv
// Shared definitions for the memory-access stage: datapath width,
// mem_op field layout, access-size and FSM state encodings.
`ifndef YSYX_22040383_XLEN
`define YSYX_22040383_XLEN 64
`endif

package ysyx_22040383_mem_stage_pkg;

  localparam int XLEN_DEF = `YSYX_22040383_XLEN;

  // in_mem_op = {is_load, is_store, size[1:0]}
  localparam int MOP_LOAD  = 3;
  localparam int MOP_STORE = 2;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } mem_size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_lsb_mask(input logic [1:0] size);
    logic [2:0] m;
    case (mem_size_e'(size))
      SZ_B:    m = 3'b000;
      SZ_H:    m = 3'b001;
      SZ_W:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ysyx_22040383_lsu_align.sv
// Combinational byte-lane logic for the memory stage: store lane shift and
// byte mask, load extract with sign/zero extension, and misalign detection.
module ysyx_22040383_lsu_align
  import ysyx_22040383_mem_stage_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int MASK_W = XLEN / 8
) (
  input  logic [1:0]        st_size,
  input  logic [2:0]        st_off,
  input  logic [XLEN-1:0]   st_data,
  output logic [XLEN-1:0]   st_wdata,
  output logic [MASK_W-1:0] st_wmask,
  output logic              misalign,
  input  logic [1:0]        ld_size,
  input  logic [2:0]        ld_off,
  input  logic              ld_unsigned,
  input  logic [XLEN-1:0]   ld_rdata,
  output logic [XLEN-1:0]   ld_data
);

  // Keep the low (1<<size) bytes of v and widen them to XLEN.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v,
                                             input logic [1:0] size,
                                             input logic uns);
    logic signed [XLEN-1:0] r;
    case (mem_size_e'(size))
      SZ_B:    r = {{(XLEN-8){~uns & v[7]}}, v[7:0]};
      SZ_H:    r = {{(XLEN-16){~uns & v[15]}}, v[15:0]};
      SZ_W:    r = {{(XLEN-32){~uns & v[31]}}, v[31:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  logic [MASK_W-1:0] base_mask;
  logic [XLEN-1:0]   ld_shifted;

  // Store path: move data and byte enables to the addressed lanes.
  always_comb begin
    case (mem_size_e'(st_size))
      SZ_B:    base_mask = MASK_W'(8'h01);
      SZ_H:    base_mask = MASK_W'(8'h03);
      SZ_W:    base_mask = MASK_W'(8'h0F);
      default: base_mask = MASK_W'(8'hFF);
    endcase
    st_wdata = st_data << {st_off, 3'b000};
    st_wmask = base_mask << st_off;
    misalign = (st_off & size_lsb_mask(st_size)) != 3'b000;
  end

  // Load path: bring the addressed bytes down to lane 0, then extend.
  always_comb begin
    ld_shifted = ld_rdata >> {ld_off, 3'b000};
    ld_data    = extend(ld_shifted, ld_size, ld_unsigned);
  end

endmodule

// File: rtl/ysyx_22040383_mem_stage.sv
// Memory-access stage: accepts one instruction per handshake from EX, runs a
// single-outstanding req/ack data-memory transaction for loads and stores,
// and drives the registered MEM/WB outputs.
module ysyx_22040383_mem_stage
  import ysyx_22040383_mem_stage_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int MASK_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [XLEN-1:0]   in_store_data,
  input  logic [3:0]        in_mem_op,
  input  logic              in_mem_unsigned,
  input  logic [4:0]        in_rd,
  input  logic              in_is_write_rf,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [MASK_W-1:0] dmem_wmask,
  input  logic              dmem_ack,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              wb_valid,
  output logic [XLEN-1:0]   wb_data,
  output logic [4:0]        wb_addr,
  output logic              wb_is_write_rf,
  output logic              wb_misalign
);

  mem_state_e state;

  // Instruction details held while the memory transaction is outstanding.
  logic [4:0] rd_p1;
  logic       write_rf_p1;
  logic       is_load_p1;
  logic       unsigned_p1;
  logic [1:0] size_p1;
  logic [2:0] off_p1;

  logic              is_load;
  logic              is_mem;
  logic [XLEN-1:0]   st_wdata;
  logic [MASK_W-1:0] st_wmask;
  logic              misalign;
  logic [XLEN-1:0]   ld_data;

  // Both is_load and is_store set resolves to a load.
  assign is_load  = in_mem_op[MOP_LOAD];
  assign is_mem   = in_mem_op[MOP_LOAD] | in_mem_op[MOP_STORE];
  assign in_ready = (state == ST_IDLE);

  ysyx_22040383_lsu_align #(
    .XLEN   (XLEN),
    .MASK_W (MASK_W)
  ) u_align (
    .st_size     (in_mem_op[1:0]),
    .st_off      (in_alu_result[2:0]),
    .st_data     (in_store_data),
    .st_wdata    (st_wdata),
    .st_wmask    (st_wmask),
    .misalign    (misalign),
    .ld_size     (size_p1),
    .ld_off      (off_p1),
    .ld_unsigned (unsigned_p1),
    .ld_rdata    (dmem_rdata),
    .ld_data     (ld_data)
  );

  // Stage FSM, data-memory request registers and MEM/WB registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      dmem_wmask     <= '0;
      wb_valid       <= 1'b0;
      wb_data        <= '0;
      wb_addr        <= '0;
      wb_is_write_rf <= 1'b0;
      wb_misalign    <= 1'b0;
      rd_p1          <= '0;
      write_rf_p1    <= 1'b0;
      is_load_p1     <= 1'b0;
      unsigned_p1    <= 1'b0;
      size_p1        <= '0;
      off_p1         <= '0;
    end else begin
      wb_valid    <= 1'b0;
      wb_misalign <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (!is_mem) begin
              wb_valid       <= 1'b1;
              wb_data        <= in_alu_result;
              wb_addr        <= in_rd;
              wb_is_write_rf <= in_is_write_rf;
            end else if (misalign) begin
              wb_valid       <= 1'b1;
              wb_misalign    <= 1'b1;
              wb_data        <= '0;
              wb_addr        <= in_rd;
              wb_is_write_rf <= 1'b0;
            end else begin
              state       <= ST_BUSY;
              dmem_req    <= 1'b1;
              dmem_we     <= ~is_load;
              dmem_addr   <= {in_alu_result[XLEN-1:3], 3'b000};
              dmem_wdata  <= is_load ? '0 : st_wdata;
              dmem_wmask  <= is_load ? '0 : st_wmask;
              rd_p1       <= in_rd;
              write_rf_p1 <= in_is_write_rf;
              is_load_p1  <= is_load;
              unsigned_p1 <= in_mem_unsigned;
              size_p1     <= in_mem_op[1:0];
              off_p1      <= in_alu_result[2:0];
            end
          end
        end
        ST_BUSY: begin
          if (dmem_ack) begin
            state    <= ST_IDLE;
            dmem_req <= 1'b0;
            wb_valid <= 1'b1;
            wb_addr  <= rd_p1;
            if (is_load_p1) begin
              wb_data        <= ld_data;
              wb_is_write_rf <= write_rf_p1;
            end else begin
              wb_data        <= '0;
              wb_is_write_rf <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040383_mem_stage.sv
// Self-checking bench for the memory-access stage: directed cases with
// literal expectations, then randomized traffic against a byte-level model.
module tb_ysyx_22040383_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_alu_result;
  logic [63:0] in_store_data;
  logic [3:0]  in_mem_op;
  logic        in_mem_unsigned;
  logic [4:0]  in_rd;
  logic        in_is_write_rf;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_wmask;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;
  logic        wb_valid;
  logic [63:0] wb_data;
  logic [4:0]  wb_addr;
  logic        wb_is_write_rf;
  logic        wb_misalign;

  always #5 clk = ~clk;

  ysyx_22040383_mem_stage #(.XLEN(64), .MASK_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_store_data(in_store_data),
    .in_mem_op(in_mem_op), .in_mem_unsigned(in_mem_unsigned),
    .in_rd(in_rd), .in_is_write_rf(in_is_write_rf),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_addr(wb_addr),
    .wb_is_write_rf(wb_is_write_rf), .wb_misalign(wb_misalign)
  );

  typedef struct {
    logic [63:0] data;
    logic [4:0]  addr;
    logic        we;
    logic        mis;
    bit          chk_addr;
  } wb_t;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  mask;
    bit          is_load;
    int          size;
    int          off;
    bit          uns;
    logic [4:0]  rd;
    logic        wrf;
  } req_t;

  wb_t  wbq[$];
  req_t reqq[$];

  int          tests = 0;
  int          fails = 0;
  bit          started = 0;
  bit          resp_en = 1;
  int          force_delay = -1;
  bit          force_rdata_en = 0;
  logic [63:0] force_rdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Byte-by-byte load result: gather the addressed bytes, then fill above.
  function automatic logic [63:0] model_load(input logic [63:0] rdata, input int off,
                                             input int size, input bit uns);
    int nb = 1 << size;
    logic [63:0] v = '0;
    for (int i = 0; i < nb; i++) v[i*8 +: 8] = rdata[(off+i)*8 +: 8];
    if (!uns && nb < 8 && v[nb*8-1])
      for (int i = nb*8; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Record what an accepted instruction must produce.
  task automatic model_accept(input logic [63:0] alu, input logic [63:0] sd,
                              input logic [3:0] op, input logic uns,
                              input logic [4:0] rd, input logic wrf);
    bit   ld = op[3];
    bit   st = op[2] & ~op[3];
    int   sz = int'(op[1:0]);
    int   nb = 1 << sz;
    int   off = int'(alu[2:0]);
    wb_t  w;
    req_t r;
    if (!ld && !st) begin
      w = '{data: alu, addr: rd, we: wrf, mis: 1'b0, chk_addr: 1'b1};
      wbq.push_back(w);
    end else if ((off % nb) != 0) begin
      w = '{data: 64'd0, addr: rd, we: 1'b0, mis: 1'b1, chk_addr: 1'b0};
      wbq.push_back(w);
    end else if (resp_en) begin
      r.we      = st;
      r.addr    = alu & ~64'h7;
      r.wdata   = sd << (off * 8);
      r.mask    = '0;
      if (st) for (int i = 0; i < nb; i++) r.mask[off+i] = 1'b1;
      r.is_load = ld;
      r.size    = sz;
      r.off     = off;
      r.uns     = uns;
      r.rd      = rd;
      r.wrf     = wrf;
      reqq.push_back(r);
    end
  endtask

  task automatic issue(input logic [63:0] alu, input logic [63:0] sd,
                       input logic [3:0] op, input logic uns,
                       input logic [4:0] rd, input logic wrf);
    int n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    if (!in_ready) begin
      chk("ready_timeout", 64'(in_ready), 64'd1);
    end else begin
      in_alu_result   = alu;
      in_store_data   = sd;
      in_mem_op       = op;
      in_mem_unsigned = uns;
      in_rd           = rd;
      in_is_write_rf  = wrf;
      in_valid        = 1'b1;
      model_accept(alu, sd, op, uns, rd, wrf);
      step();
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_wb(output int held);
    int n = 0;
    held = 0;
    while (!wb_valid && n < 20) begin
      if (dmem_req) held++;
      step();
      n++;
    end
    chk("wb_arrived", 64'(wb_valid), 64'd1);
  endtask

  // Memory responder: checks each request, acks after a delay, predicts wb.
  initial begin
    req_t        r;
    int          d;
    logic [63:0] rdata;
    wb_t         w;
    wait (started);
    forever begin
      step();
      dmem_ack = 1'b0;
      if (!resp_en) continue;
      if (dmem_req) begin
        if (reqq.size() == 0) begin
          chk("unexpected_req", 64'(dmem_req), 64'd0);
          dmem_ack = 1'b1;
          step();
          dmem_ack = 1'b0;
          continue;
        end
        r = reqq.pop_front();
        chk("req_we", 64'(dmem_we), 64'(r.we));
        chk("req_addr", dmem_addr, r.addr);
        chk("req_wmask", 64'(dmem_wmask), 64'(r.mask));
        if (r.we) chk("req_wdata", dmem_wdata, r.wdata);
        chk("busy_not_ready", 64'(in_ready), 64'd0);
        d = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
        for (int k = 0; k < d; k++) begin
          step();
          chk("req_held", 64'(dmem_req), 64'd1);
          chk("req_addr_stable", dmem_addr, r.addr);
          chk("req_wmask_stable", 64'(dmem_wmask), 64'(r.mask));
          chk("busy_not_ready", 64'(in_ready), 64'd0);
        end
        rdata = force_rdata_en ? force_rdata : {$urandom, $urandom};
        dmem_rdata = rdata;
        dmem_ack   = 1'b1;
        if (r.is_load)
          w = '{data: model_load(rdata, r.off, r.size, r.uns), addr: r.rd,
                we: r.wrf, mis: 1'b0, chk_addr: 1'b1};
        else
          w = '{data: 64'd0, addr: r.rd, we: 1'b0, mis: 1'b0, chk_addr: 1'b0};
        wbq.push_back(w);
        step();
        dmem_ack   = 1'b0;
        dmem_rdata = {$urandom, $urandom};
        chk("req_dropped", 64'(dmem_req), 64'd0);
        chk("ready_after_ack", 64'(in_ready), 64'd1);
      end else if ($urandom_range(0, 3) == 0) begin
        // Stray ack while idle must be ignored.
        dmem_ack   = 1'b1;
        dmem_rdata = {$urandom, $urandom};
      end
    end
  end

  // Compare process: checks MEM/WB outputs against the model every cycle.
  initial begin
    logic [63:0] last_data = '0;
    logic [4:0]  last_addr = '0;
    logic        last_we = 1'b0;
    logic        prev_rst = 1'b0;
    wb_t         e;
    wait (started);
    forever begin
      @(negedge clk);
      if (prev_rst) begin
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_wb_data", wb_data, 64'd0);
        last_data = '0;
        last_addr = '0;
        last_we   = 1'b0;
      end else if (wb_valid) begin
        if (wbq.size() == 0) begin
          chk("wb_unexpected", 64'(wb_valid), 64'd0);
        end else begin
          e = wbq.pop_front();
          chk("wb_data", wb_data, e.data);
          chk("wb_is_write_rf", 64'(wb_is_write_rf), 64'(e.we));
          chk("wb_misalign", 64'(wb_misalign), 64'(e.mis));
          if (e.chk_addr) chk("wb_addr", 64'(wb_addr), 64'(e.addr));
          last_data = e.data;
          last_we   = e.we;
        end
        last_addr = wb_addr;
      end else begin
        chk("hold_data", wb_data, last_data);
        chk("hold_addr", 64'(wb_addr), 64'(last_addr));
        chk("hold_we", 64'(wb_is_write_rf), 64'(last_we));
        chk("misalign_idle", 64'(wb_misalign), 64'd0);
      end
      prev_rst = rst;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // Driver: reset, directed cases, randomized traffic, summary.
  initial begin
    int held;
    int n;
    logic [3:0]  op;
    logic [63:0] addr;
    int sz;
    rst = 1'b1; in_valid = 1'b0; in_alu_result = '0; in_store_data = '0;
    in_mem_op = '0; in_mem_unsigned = 1'b0; in_rd = '0; in_is_write_rf = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) step();
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_dmem_req", 64'(dmem_req), 64'd0);
    chk("reset_dmem_we", 64'(dmem_we), 64'd0);
    chk("reset_dmem_wmask", 64'(dmem_wmask), 64'd0);
    chk("reset_wb_valid", 64'(wb_valid), 64'd0);
    chk("reset_wb_data", wb_data, 64'd0);
    chk("reset_wb_we", 64'(wb_is_write_rf), 64'd0);
    chk("reset_wb_misalign", 64'(wb_misalign), 64'd0);
    rst = 1'b0;
    started = 1;

    // ALU pass-through, three back-to-back.
    for (int k = 0; k < 3; k++) begin
      issue(64'h1234, 64'd0, 4'b0000, 1'b0, 5'd5, 1'b1);
      chk("alu_wb_valid", 64'(wb_valid), 64'd1);
      chk("alu_wb_data", wb_data, 64'h1234);
      chk("alu_wb_addr", 64'(wb_addr), 64'd5);
      chk("alu_no_req", 64'(dmem_req), 64'd0);
    end
    step();

    // Signed byte load, ack after 3 waiting cycles.
    force_delay = 3; force_rdata_en = 1; force_rdata = 64'h0000_0000_8000_0000;
    issue(64'h1003, 64'h0, 4'b1000, 1'b0, 5'd7, 1'b1);
    chk("lb_req", 64'(dmem_req), 64'd1);
    chk("lb_addr", dmem_addr, 64'h1000);
    chk("lb_ready", 64'(in_ready), 64'd0);
    chk("lb_we", 64'(dmem_we), 64'd0);
    chk("lb_wmask", 64'(dmem_wmask), 64'd0);
    wait_wb(held);
    chk("lb_req_cycles", 64'(held), 64'd4);
    chk("lb_data", wb_data, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_we_rf", 64'(wb_is_write_rf), 64'd1);
    step();

    // Unsigned halfword load.
    force_delay = 1; force_rdata = 64'hBEEF_0000_0000_0000;
    issue(64'h2006, 64'h0, 4'b1001, 1'b1, 5'd9, 1'b1);
    wait_wb(held);
    chk("lhu_data", wb_data, 64'h0000_0000_0000_BEEF);
    step();

    // Word store acked in the first request cycle.
    force_delay = 0;
    issue(64'h3004, 64'hDEAD_BEEF, 4'b0110, 1'b0, 5'd3, 1'b1);
    chk("sw_we", 64'(dmem_we), 64'd1);
    chk("sw_addr", dmem_addr, 64'h3000);
    chk("sw_wdata", dmem_wdata, 64'hDEAD_BEEF_0000_0000);
    chk("sw_wmask", 64'(dmem_wmask), 64'hF0);
    wait_wb(held);
    chk("sw_we_rf", 64'(wb_is_write_rf), 64'd0);
    step();

    // Misaligned doubleword load.
    issue(64'h4004, 64'h0, 4'b1011, 1'b0, 5'd4, 1'b1);
    chk("mis_wb_valid", 64'(wb_valid), 64'd1);
    chk("mis_flag", 64'(wb_misalign), 64'd1);
    chk("mis_we_rf", 64'(wb_is_write_rf), 64'd0);
    chk("mis_ready", 64'(in_ready), 64'd1);
    chk("mis_no_req", 64'(dmem_req), 64'd0);
    repeat (2) step();

    // Reset while waiting for ack, then a late ack.
    resp_en = 0;
    step();
    issue(64'h5000, 64'h0, 4'b1011, 1'b0, 5'd6, 1'b1);
    repeat (2) step();
    chk("abort_req_before", 64'(dmem_req), 64'd1);
    chk("abort_ready_before", 64'(in_ready), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_req_after", 64'(dmem_req), 64'd0);
    chk("abort_ready_after", 64'(in_ready), 64'd1);
    chk("abort_wb_valid", 64'(wb_valid), 64'd0);
    dmem_rdata = 64'h1122_3344_5566_7788;
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    chk("late_ack_wb_valid", 64'(wb_valid), 64'd0);
    chk("late_ack_req", 64'(dmem_req), 64'd0);
    chk("late_ack_ready", 64'(in_ready), 64'd1);
    step();
    resp_en = 1;
    force_delay = -1; force_rdata_en = 0;
    step();

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      repeat ($urandom_range(0, 2)) step();
      addr = {$urandom, $urandom};
      sz = int'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0, 1:    op = 4'b0000;
        2, 3:    op = {2'b10, 2'(sz)};
        4:       op = {2'b01, 2'(sz)};
        default: op = {2'b11, 2'(sz)};
      endcase
      if ($urandom_range(0, 3) != 0) addr = addr & ~64'((1 << sz) - 1);
      issue(addr, {$urandom, $urandom}, op, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    n = 0;
    while ((!in_ready || wbq.size() != 0 || reqq.size() != 0) && n < 100) begin
      step();
      n++;
    end
    repeat (3) step();
    chk("drain_wb", 64'(wbq.size()), 64'd0);
    chk("drain_req", 64'(reqq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
